// File: rtl/fetch_line_ctrl.sv
// Fetch-line sequencer: owns the fetch PC, issues one line request at a time,
// forwards returned lines to the ibuffer and drops responses made stale by redirects.
module fetch_line_ctrl #(
  parameter int unsigned     PC_W     = 48,
  parameter int unsigned     LINE_W   = 512,
  parameter logic [PC_W-1:0] RESET_PC = '0,
  parameter int unsigned     HOLDOFF  = 16
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              redirect_valid,
  input  logic [PC_W-1:0]   redirect_pc,
  input  logic              ibuf_fetch_inst,
  input  logic              ibuf_empty,
  output logic              mem_req_valid,
  input  logic              mem_req_ready,
  output logic [PC_W-1:0]   mem_req_addr,
  input  logic              mem_resp_valid,
  input  logic [LINE_W-1:0] mem_resp_data,
  output logic              ibuf_line_valid,
  output logic [LINE_W-1:0] ibuf_line_data,
  output logic [PC_W-1:0]   ibuf_line_pc,
  output logic [3:0]        ibuf_line_skip,
  output logic              ibuf_clear,
  output logic              can_fetch_inst,
  output logic              busy
);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_REQ  = 2'd1;
  localparam logic [1:0] ST_WAIT = 2'd2;
  localparam logic [1:0] ST_DROP = 2'd3;

  localparam int unsigned       HOLD_W     = (HOLDOFF > 0) ? $clog2(HOLDOFF + 1) : 1;
  localparam logic [HOLD_W-1:0] HOLD_INIT  = HOLD_W'(HOLDOFF);
  localparam logic [PC_W-1:0]   LINE_BYTES = PC_W'(64);

  logic [1:0]        state_q,      state_d;
  logic [PC_W-1:0]   fetch_pc_q,   fetch_pc_d;
  logic [3:0]        skip_q,       skip_d;
  logic [HOLD_W-1:0] holdoff_q,    holdoff_d;
  logic              line_valid_q, line_valid_d;
  logic [LINE_W-1:0] line_data_q,  line_data_d;
  logic [PC_W-1:0]   line_pc_q,    line_pc_d;
  logic [3:0]        line_skip_q,  line_skip_d;
  logic              clear_q,      clear_d;

  // Redirect targets are word-aligned; the byte offset bits carry no information.
  logic unused_redirect_lsbs;
  assign unused_redirect_lsbs = ^redirect_pc[1:0];

  always_comb begin
    // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
    state_d      = state_q;
    fetch_pc_d   = fetch_pc_q;
    skip_d       = skip_q;
    holdoff_d    = (holdoff_q != '0) ? holdoff_q - HOLD_W'(1) : '0;
    line_valid_d = 1'b0;
    line_data_d  = line_data_q;
    line_pc_d    = line_pc_q;
    line_skip_d  = line_skip_q;
    clear_d      = 1'b0;

    case (state_q)
      ST_IDLE: begin
        if (holdoff_q == '0 && (ibuf_fetch_inst || ibuf_empty)) state_d = ST_REQ;
      end
      ST_REQ: begin
        if (mem_req_ready) state_d = ST_WAIT;
      end
      ST_WAIT: begin
        if (mem_resp_valid) begin
          state_d      = ST_IDLE;
          line_valid_d = 1'b1;
          line_data_d  = mem_resp_data;
          line_pc_d    = fetch_pc_q;
          line_skip_d  = skip_q;
          fetch_pc_d   = fetch_pc_q + LINE_BYTES;
          skip_d       = 4'd0;
          holdoff_d    = HOLD_INIT;
        end
      end
      default: begin
        if (mem_resp_valid) state_d = ST_REQ;
      end
    endcase

    // Redirect overrides everything; a request already handed to memory leaves one stale response.
    if (redirect_valid) begin
      fetch_pc_d   = {redirect_pc[PC_W-1:6], 6'b0};
      skip_d       = redirect_pc[5:2];
      holdoff_d    = '0;
      clear_d      = 1'b1;
      line_valid_d = 1'b0;
      case (state_q)
        ST_IDLE: state_d = ST_REQ;
        ST_REQ:  state_d = mem_req_ready  ? ST_DROP : ST_REQ;
        ST_WAIT: state_d = mem_resp_valid ? ST_REQ  : ST_DROP;
        default: state_d = ST_DROP;
      endcase
    end
  end

  // NOTE: the wide line register is reset too, so ibuf_line_data reads 0 until the first delivery.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q      <= ST_REQ;
      fetch_pc_q   <= RESET_PC;
      skip_q       <= 4'd0;
      holdoff_q    <= '0;
      line_valid_q <= 1'b0;
      line_data_q  <= '0;
      line_pc_q    <= '0;
      line_skip_q  <= 4'd0;
      clear_q      <= 1'b0;
    end else begin
      state_q      <= state_d;
      fetch_pc_q   <= fetch_pc_d;
      skip_q       <= skip_d;
      holdoff_q    <= holdoff_d;
      line_valid_q <= line_valid_d;
      line_data_q  <= line_data_d;
      line_pc_q    <= line_pc_d;
      line_skip_q  <= line_skip_d;
      clear_q      <= clear_d;
    end
  end

  assign mem_req_valid   = (state_q == ST_REQ);
  assign mem_req_addr    = fetch_pc_q;
  assign ibuf_line_valid = line_valid_q;
  assign ibuf_line_data  = line_data_q;
  assign ibuf_line_pc    = line_pc_q;
  assign ibuf_line_skip  = line_skip_q;
  assign ibuf_clear      = clear_q;
  assign can_fetch_inst  = (state_q == ST_IDLE) && (holdoff_q == '0);
  assign busy            = (state_q != ST_IDLE);

endmodule

// File: tb/tb_fetch_line_ctrl.sv
// Self-checking bench for fetch_line_ctrl: directed scenarios with literal expectations,
// then randomized traffic, all compared every cycle against a request/response-count model.
module tb_fetch_line_ctrl;

  localparam int PC_W    = 48;
  localparam int LINE_W  = 512;
  localparam int HOLDOFF = 16;

  logic              clock = 1'b0;
  logic              reset_n;
  logic              redirect_valid;
  logic [PC_W-1:0]   redirect_pc;
  logic              ibuf_fetch_inst;
  logic              ibuf_empty;
  logic              mem_req_valid;
  logic              mem_req_ready;
  logic [PC_W-1:0]   mem_req_addr;
  logic              mem_resp_valid;
  logic [LINE_W-1:0] mem_resp_data;
  logic              ibuf_line_valid;
  logic [LINE_W-1:0] ibuf_line_data;
  logic [PC_W-1:0]   ibuf_line_pc;
  logic [3:0]        ibuf_line_skip;
  logic              ibuf_clear;
  logic              can_fetch_inst;
  logic              busy;

  fetch_line_ctrl #(.PC_W(PC_W), .LINE_W(LINE_W), .RESET_PC('0), .HOLDOFF(HOLDOFF)) dut (
    .clock           (clock),
    .reset_n         (reset_n),
    .redirect_valid  (redirect_valid),
    .redirect_pc     (redirect_pc),
    .ibuf_fetch_inst (ibuf_fetch_inst),
    .ibuf_empty      (ibuf_empty),
    .mem_req_valid   (mem_req_valid),
    .mem_req_ready   (mem_req_ready),
    .mem_req_addr    (mem_req_addr),
    .mem_resp_valid  (mem_resp_valid),
    .mem_resp_data   (mem_resp_data),
    .ibuf_line_valid (ibuf_line_valid),
    .ibuf_line_data  (ibuf_line_data),
    .ibuf_line_pc    (ibuf_line_pc),
    .ibuf_line_skip  (ibuf_line_skip),
    .ibuf_clear      (ibuf_clear),
    .can_fetch_inst  (can_fetch_inst),
    .busy            (busy)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a pending request, an accepted request awaiting data, and whether that data is stale.
  bit                m_req;
  bit                m_inflight;
  bit                m_stale;
  logic [PC_W-1:0]   m_pc;
  logic [3:0]        m_skip;
  int                m_hold;
  bit                m_lv;
  logic [LINE_W-1:0] m_ldata;
  logic [PC_W-1:0]   m_lpc;
  logic [3:0]        m_lskip;
  bit                m_clear;

  task automatic check(input string name, input logic [LINE_W-1:0] act, input logic [LINE_W-1:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %0h required %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_req = 1'b1; m_inflight = 1'b0; m_stale = 1'b0;
    m_pc = '0; m_skip = '0; m_hold = 0;
    m_lv = 1'b0; m_ldata = '0; m_lpc = '0; m_lskip = '0; m_clear = 1'b0;
  endtask

  task automatic model_step();
    bit idle, accepted, outstanding;
    int hold_now;
    idle     = !m_req && !m_inflight;
    accepted = m_req && mem_req_ready;
    hold_now = m_hold;
    m_hold   = (m_hold > 0) ? m_hold - 1 : 0;
    m_lv     = 1'b0;
    m_clear  = 1'b0;
    if (redirect_valid) begin
      outstanding = accepted || (m_inflight && (m_stale || !mem_resp_valid));
      m_pc       = redirect_pc & ~48'h3F;
      m_skip     = redirect_pc[5:2];
      m_hold     = 0;
      m_clear    = 1'b1;
      m_req      = !outstanding;
      m_inflight = outstanding;
      m_stale    = outstanding;
    end else if (idle) begin
      if (hold_now == 0 && (ibuf_fetch_inst || ibuf_empty)) m_req = 1'b1;
    end else if (m_req) begin
      if (mem_req_ready) begin
        m_req = 1'b0; m_inflight = 1'b1; m_stale = 1'b0;
      end
    end else if (mem_resp_valid) begin
      m_inflight = 1'b0;
      if (m_stale) begin
        m_stale = 1'b0;
        m_req   = 1'b1;
      end else begin
        m_lv    = 1'b1;
        m_ldata = mem_resp_data;
        m_lpc   = m_pc;
        m_lskip = m_skip;
        m_pc    = m_pc + 48'd64;
        m_skip  = '0;
        m_hold  = HOLDOFF;
      end
    end
  endtask

  task automatic compare_all();
    check("req_valid",  mem_req_valid,   m_req);
    check("busy",       busy,            m_req || m_inflight);
    check("can_fetch",  can_fetch_inst,  !m_req && !m_inflight && m_hold == 0);
    check("line_valid", ibuf_line_valid, m_lv);
    check("clear",      ibuf_clear,      m_clear);
    if (m_req) check("req_addr", mem_req_addr, m_pc);
    if (m_lv) begin
      check("line_data", ibuf_line_data, m_ldata);
      check("line_pc",   ibuf_line_pc,   m_lpc);
      check("line_skip", ibuf_line_skip, m_lskip);
    end
  endtask

  // Inputs are set at the negedge before calling; the model advances at the posedge, outputs are compared at the negedge.
  task automatic tick();
    @(posedge clock);
    model_step();
    @(negedge clock);
    compare_all();
  endtask

  function automatic logic [LINE_W-1:0] rand_line();
    logic [LINE_W-1:0] l;
    for (int i = 0; i < LINE_W / 32; i++) l[i*32 +: 32] = $urandom;
    return l;
  endfunction

  task automatic serve(input int delay, output logic [LINE_W-1:0] d);
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    repeat (delay) tick();
    d = rand_line();
    mem_resp_valid = 1'b1;
    mem_resp_data  = d;
    tick();
    mem_resp_valid = 1'b0;
  endtask

  task automatic do_redirect(input logic [PC_W-1:0] pc);
    redirect_valid = 1'b1;
    redirect_pc    = pc;
    tick();
    redirect_valid = 1'b0;
  endtask

  task automatic wait_hold();
    for (int i = 0; i < HOLDOFF + 4 && m_hold != 0; i++) tick();
  endtask

  task automatic trigger();
    ibuf_fetch_inst = 1'b1;
    tick();
    ibuf_fetch_inst = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not complete");
    $fatal(1);
  end

  initial begin
    logic [LINE_W-1:0] d;
    logic [63:0]       rp;

    reset_n = 1'b0;
    redirect_valid = 1'b0; redirect_pc = '0;
    ibuf_fetch_inst = 1'b0; ibuf_empty = 1'b0;
    mem_req_ready = 1'b0; mem_resp_valid = 1'b0; mem_resp_data = '0;
    model_reset();
    repeat (2) @(negedge clock);

    // Reset state
    check("rst_req_valid",  mem_req_valid,   1'b1);
    check("rst_req_addr",   mem_req_addr,    48'h0);
    check("rst_busy",       busy,            1'b1);
    check("rst_line_valid", ibuf_line_valid, 1'b0);
    check("rst_line_data",  ibuf_line_data,  '0);
    check("rst_clear",      ibuf_clear,      1'b0);
    check("rst_can_fetch",  can_fetch_inst,  1'b0);
    compare_all();
    reset_n = 1'b1;

    // 1: first line, response three cycles after acceptance
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    check("t1_wait_no_req", mem_req_valid, 1'b0);
    tick();
    tick();
    d = rand_line();
    mem_resp_valid = 1'b1; mem_resp_data = d;
    tick();
    mem_resp_valid = 1'b0;
    check("t1_line_valid", ibuf_line_valid, 1'b1);
    check("t1_line_pc",    ibuf_line_pc,    48'h0);
    check("t1_line_skip",  ibuf_line_skip,  4'd0);
    check("t1_line_data",  ibuf_line_data,  d);
    check("t1_idle",       busy,            1'b0);

    // 2: refill trigger during holdoff is ignored; ibuf_empty after holdoff fetches 0x40
    repeat (4) tick();
    trigger();
    check("t2_ignored_req",  mem_req_valid,  1'b0);
    check("t2_ignored_busy", busy,           1'b0);
    wait_hold();
    check("t2_can_fetch", can_fetch_inst, 1'b1);
    ibuf_empty = 1'b1;
    tick();
    ibuf_empty = 1'b0;
    check("t2_req_valid", mem_req_valid, 1'b1);
    check("t2_req_addr",  mem_req_addr,  48'h40);
    serve(2, d);
    check("t2_line_pc", ibuf_line_pc, 48'h40);

    // 3: redirect to 0x1008 in IDLE
    do_redirect(48'h1008);
    check("t3_clear",     ibuf_clear,    1'b1);
    check("t3_req_valid", mem_req_valid, 1'b1);
    check("t3_req_addr",  mem_req_addr,  48'h1000);
    tick();
    check("t3_clear_once", ibuf_clear, 1'b0);
    serve(1, d);
    check("t3_line_pc",   ibuf_line_pc,   48'h1000);
    check("t3_line_skip", ibuf_line_skip, 4'd2);
    wait_hold();
    trigger();
    check("t3_next_addr", mem_req_addr, 48'h1040);
    serve(0, d);
    check("t3_next_pc",   ibuf_line_pc,   48'h1040);
    check("t3_next_skip", ibuf_line_skip, 4'd0);

    // 4: redirect while waiting, stale response two cycles later
    wait_hold();
    trigger();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    do_redirect(48'h2000);
    check("t4_clear",   ibuf_clear,    1'b1);
    check("t4_no_req",  mem_req_valid, 1'b0);
    check("t4_busy",    busy,          1'b1);
    tick();
    mem_resp_valid = 1'b1; mem_resp_data = rand_line();
    tick();
    mem_resp_valid = 1'b0;
    check("t4_stale_dropped", ibuf_line_valid, 1'b0);
    check("t4_req_valid",     mem_req_valid,   1'b1);
    check("t4_req_addr",      mem_req_addr,    48'h2000);
    serve(0, d);
    check("t4_line_pc", ibuf_line_pc, 48'h2000);

    // 5: redirect coincides with the response
    wait_hold();
    trigger();
    mem_req_ready = 1'b1;
    tick();
    mem_req_ready = 1'b0;
    mem_resp_valid = 1'b1; mem_resp_data = rand_line();
    redirect_valid = 1'b1; redirect_pc = 48'h3004;
    tick();
    mem_resp_valid = 1'b0; redirect_valid = 1'b0;
    check("t5_no_line",   ibuf_line_valid, 1'b0);
    check("t5_clear",     ibuf_clear,      1'b1);
    check("t5_req_valid", mem_req_valid,   1'b1);
    check("t5_req_addr",  mem_req_addr,    48'h3000);
    serve(0, d);
    check("t5_line_pc",   ibuf_line_pc,   48'h3000);
    check("t5_line_skip", ibuf_line_skip, 4'd1);

    // Back-to-back redirects: last wins, clear in each following cycle
    do_redirect(48'h100);
    do_redirect(48'h204);
    check("bb_clear",    ibuf_clear,   1'b1);
    check("bb_req_addr", mem_req_addr, 48'h200);
    tick();
    check("bb_clear_end", ibuf_clear, 1'b0);
    serve(0, d);
    check("bb_line_skip", ibuf_line_skip, 4'd1);

    // 6: PC wrap at the top of the address space
    do_redirect(48'hFFFF_FFFF_FFC0);
    serve(0, d);
    check("t6_line_pc", ibuf_line_pc, 48'hFFFF_FFFF_FFC0);
    wait_hold();
    trigger();
    check("t6_wrap_addr", mem_req_addr, 48'h0);

    // Randomized traffic against the model
    for (int c = 0; c < 3000; c++) begin
      rp = {$urandom, $urandom};
      redirect_valid  = ($urandom_range(0, 15) == 0);
      redirect_pc     = rp[PC_W-1:0] & ~48'h3;
      ibuf_fetch_inst = ($urandom_range(0, 3) == 0);
      ibuf_empty      = ($urandom_range(0, 7) == 0);
      mem_req_ready   = $urandom_range(0, 1) == 1;
      mem_resp_valid  = ($urandom_range(0, 2) == 0);
      mem_resp_data   = rand_line();
      tick();
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
